// File: rtl/fp_sqrt_pkg.sv
// Shared constants for the floating-point square-root datapath: default widths
// and the ALU operation encoding used by the controller.
package fp_sqrt_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 3;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_XOR   = 3'b100;
  localparam logic [2:0] ALU_SHR1  = 3'b101;
  localparam logic [2:0] ALU_SHL1  = 3'b110;
  localparam logic [2:0] ALU_PASSA = 3'b111;

endpackage

// File: rtl/fp_sqrt_regfile.sv
// Register file for the square-root datapath: two asynchronous read ports,
// one synchronous write port, synchronous clear of every entry.
module fp_sqrt_regfile
  import fp_sqrt_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int AW = ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rda,
  output logic [DW-1:0] rdb
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];

  // NOTE: every entry is cleared on reset because the controller assumes all
  // registers read zero afterwards; this keeps the array in flops, not RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      // NOTE: non-blocking so same-cycle readers see the old value until the edge.
      mem[waddr] <= wdata;
    end
  end

  assign rda = mem[raddr_a];
  assign rdb = mem[raddr_b];

endmodule

// File: rtl/fp_sqrt_datapath.sv
// Datapath of the floating-point square-root unit: register file, integer ALU,
// write-back mux, N/Z flags and a registered result, all steered by an external FSM.
module fp_sqrt_datapath
  import fp_sqrt_pkg::*;
#(
  parameter int DATA_WIDTH_P = DATA_WIDTH,
  parameter int ADDR_WIDTH_P = ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH_P-1:0] data_i,
  input  logic                    mux_sel,
  input  logic                    we,
  input  logic [ADDR_WIDTH_P-1:0] waddr,
  input  logic [ADDR_WIDTH_P-1:0] raddr_a,
  input  logic [ADDR_WIDTH_P-1:0] raddr_b,
  input  logic [2:0]              alu_op,
  input  logic                    oe,
  output logic [DATA_WIDTH_P-1:0] data_o,
  output logic                    negative_o,
  output logic                    zero_o,
  output logic [DATA_WIDTH_P-1:0] mux_o,
  output logic [DATA_WIDTH_P-1:0] RDA_o,
  output logic [DATA_WIDTH_P-1:0] RDB_o,
  output logic [DATA_WIDTH_P-1:0] ALU_o
);

  logic [DATA_WIDTH_P-1:0] alu_res;

  fp_sqrt_regfile #(
    .DW (DATA_WIDTH_P),
    .AW (ADDR_WIDTH_P)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (mux_o),
    .raddr_a (raddr_a),
    .raddr_b (raddr_b),
    .rda     (RDA_o),
    .rdb     (RDB_o)
  );

  // Arithmetic wraps modulo 2**DATA_WIDTH; there is no carry or overflow out.
  always_comb begin
    // NOTE: default assignment first so no path through the case can infer a latch.
    alu_res = RDA_o;
    case (alu_op)
      ALU_ADD:   alu_res = RDA_o + RDB_o;
      ALU_SUB:   alu_res = RDA_o - RDB_o;
      ALU_AND:   alu_res = RDA_o & RDB_o;
      ALU_OR:    alu_res = RDA_o | RDB_o;
      ALU_XOR:   alu_res = RDA_o ^ RDB_o;
      ALU_SHR1:  alu_res = RDA_o >> 1;
      ALU_SHL1:  alu_res = RDA_o << 1;
      ALU_PASSA: alu_res = RDA_o;
      default:   alu_res = RDA_o;
    endcase
  end

  assign ALU_o      = alu_res;
  assign negative_o = alu_res[DATA_WIDTH_P-1];
  assign zero_o     = (alu_res == '0);
  assign mux_o      = mux_sel ? alu_res : data_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_o <= '0;
    end else if (oe) begin
      data_o <= alu_res;
    end
  end

endmodule

// File: tb/tb_fp_sqrt_datapath.sv
// Self-checking bench for fp_sqrt_datapath: expected values are queued as
// stimulus is driven and compared once the DUT outputs have settled.
module tb_fp_sqrt_datapath;
  import fp_sqrt_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_i;
  logic        mux_sel;
  logic        we;
  logic [2:0]  waddr;
  logic [2:0]  raddr_a;
  logic [2:0]  raddr_b;
  logic [2:0]  alu_op;
  logic        oe;
  logic [31:0] data_o;
  logic        negative_o;
  logic        zero_o;
  logic [31:0] mux_o;
  logic [31:0] RDA_o;
  logic [31:0] RDB_o;
  logic [31:0] ALU_o;

  always #5 clk = ~clk;

  fp_sqrt_datapath dut (
    .clk        (clk),
    .rst        (rst),
    .data_i     (data_i),
    .mux_sel    (mux_sel),
    .we         (we),
    .waddr      (waddr),
    .raddr_a    (raddr_a),
    .raddr_b    (raddr_b),
    .alu_op     (alu_op),
    .oe         (oe),
    .data_o     (data_o),
    .negative_o (negative_o),
    .zero_o     (zero_o),
    .mux_o      (mux_o),
    .RDA_o      (RDA_o),
    .RDB_o      (RDB_o),
    .ALU_o      (ALU_o)
  );

  typedef enum {SEL_RDA, SEL_RDB, SEL_ALU, SEL_MUX, SEL_DO, SEL_NEG, SEL_ZERO} sel_e;
  typedef struct {
    string       tag;
    sel_e        sel;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] ref_r [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return {1'b0, a[31:1]};
      3'd6:    return {a[30:0], 1'b0};
      default: return a;
    endcase
  endfunction

  function automatic logic [31:0] observe(input sel_e s);
    case (s)
      SEL_RDA:  return RDA_o;
      SEL_RDB:  return RDB_o;
      SEL_ALU:  return ALU_o;
      SEL_MUX:  return mux_o;
      SEL_DO:   return data_o;
      SEL_NEG:  return {31'b0, negative_o};
      default:  return {31'b0, zero_o};
    endcase
  endfunction

  task automatic push(input string tag, input sel_e s, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = s;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sel), e.val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] addr, input logic [31:0] val);
    data_i  = val;
    mux_sel = 1'b0;
    we      = 1'b1;
    waddr   = addr;
    step();
    we = 1'b0;
    ref_r[addr] = val;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 8; i++) begin
      raddr_a = 3'(i);
      raddr_b = 3'(7 - i);
      push({tag, "_rda"}, SEL_RDA, 32'h0);
      push({tag, "_rdb"}, SEL_RDB, 32'h0);
      drain();
    end
  endtask

  localparam logic [2:0]  OPS      [8] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
                                           ALU_XOR, ALU_SHR1, ALU_SHL1, ALU_PASSA};
  localparam logic [31:0] OPS_EXP  [8] = '{32'd8, 32'd2, 32'd1, 32'd7,
                                           32'd6, 32'd2, 32'd10, 32'd5};

  initial begin
    rst = 1'b1; we = 1'b1; oe = 1'b1; mux_sel = 1'b0;
    data_i = 32'hDEAD_BEEF; waddr = 3'd2;
    raddr_a = 3'd0; raddr_b = 3'd0; alu_op = ALU_ADD;
    step();
    waddr = 3'd5;
    step();
    rst = 1'b0; we = 1'b0; oe = 1'b0;
    foreach (ref_r[i]) ref_r[i] = 32'h0;

    // Reset state
    check_all_zero("reset");
    alu_op = ALU_ADD;
    push("reset_data_o", SEL_DO, 32'h0);
    push("reset_zero", SEL_ZERO, 32'h1);
    push("reset_neg", SEL_NEG, 32'h0);
    drain();

    // Load an external operand
    load(3'd1, 32'h4080_0000);
    raddr_a = 3'd1;
    push("load_rda", SEL_RDA, 32'h4080_0000);
    drain();

    // All eight ALU operations on R1=5, R2=3
    load(3'd1, 32'd5);
    load(3'd2, 32'd3);
    raddr_a = 3'd1;
    raddr_b = 3'd2;
    for (int i = 0; i < 8; i++) begin
      alu_op = OPS[i];
      push($sformatf("alu_op%0d", i), SEL_ALU, OPS_EXP[i]);
      push($sformatf("mux_data_op%0d", i), SEL_MUX, data_i);
      drain();
    end

    // Flags: negative result, then equal operands
    load(3'd1, 32'd3);
    load(3'd2, 32'd5);
    alu_op = ALU_SUB;
    push("sub_neg_alu", SEL_ALU, 32'hFFFF_FFFE);
    push("sub_neg_n", SEL_NEG, 32'h1);
    push("sub_neg_z", SEL_ZERO, 32'h0);
    drain();
    load(3'd1, 32'd7);
    load(3'd2, 32'd7);
    push("sub_eq_alu", SEL_ALU, 32'h0);
    push("sub_eq_n", SEL_NEG, 32'h0);
    push("sub_eq_z", SEL_ZERO, 32'h1);
    drain();

    // Write-back through the mux, then the output register
    load(3'd1, 32'd5);
    load(3'd2, 32'd3);
    alu_op = ALU_ADD; mux_sel = 1'b1; we = 1'b1; waddr = 3'd3;
    push("wb_mux", SEL_MUX, 32'd8);
    drain();
    step();
    we = 1'b0; mux_sel = 1'b0;
    ref_r[3] = 32'd8;
    raddr_a = 3'd3; alu_op = ALU_PASSA; oe = 1'b1;
    push("wb_r3", SEL_ALU, 32'd8);
    push("pre_oe_data_o", SEL_DO, 32'h0);
    drain();
    step();
    oe = 1'b0;
    push("oe_data_o", SEL_DO, 32'd8);
    drain();
    raddr_a = 3'd1; alu_op = ALU_SUB;
    for (int i = 0; i < 3; i++) begin
      step();
      push($sformatf("hold_data_o%0d", i), SEL_DO, 32'd8);
      drain();
    end

    // Read-during-write on the same address
    load(3'd4, 32'h1111_1111);
    raddr_a = 3'd4; data_i = 32'h2222_2222; mux_sel = 1'b0; we = 1'b1; waddr = 3'd4;
    push("rdw_old", SEL_RDA, 32'h1111_1111);
    drain();
    step();
    we = 1'b0;
    ref_r[4] = 32'h2222_2222;
    push("rdw_new", SEL_RDA, 32'h2222_2222);
    drain();

    // Reset coincident with write and output enable
    rst = 1'b1; we = 1'b1; oe = 1'b1; waddr = 3'd5; data_i = 32'h0000_ABCD;
    step();
    rst = 1'b0; we = 1'b0; oe = 1'b0;
    foreach (ref_r[i]) ref_r[i] = 32'h0;
    check_all_zero("midrst");
    push("midrst_data_o", SEL_DO, 32'h0);
    drain();

    // Random operands and ops against the reference model, with write-back
    for (int i = 0; i < 8; i++) load(3'(i), $urandom());
    for (int i = 0; i < 24; i++) begin
      logic [2:0]  a, b, w, op;
      logic [31:0] exp;
      a = 3'($urandom_range(0, 7));
      b = 3'($urandom_range(0, 7));
      w = 3'($urandom_range(0, 7));
      op = 3'($urandom_range(0, 7));
      raddr_a = a; raddr_b = b; alu_op = op;
      exp = ref_alu(ref_r[a], ref_r[b], op);
      push($sformatf("rnd%0d_alu", i), SEL_ALU, exp);
      push($sformatf("rnd%0d_z", i), SEL_ZERO, {31'b0, exp == 32'h0});
      push($sformatf("rnd%0d_n", i), SEL_NEG, {31'b0, exp[31]});
      drain();
      mux_sel = 1'b1; we = 1'b1; waddr = w; oe = 1'b1;
      step();
      mux_sel = 1'b0; we = 1'b0; oe = 1'b0;
      ref_r[w] = exp;
      raddr_a = w;
      push($sformatf("rnd%0d_wb", i), SEL_RDA, exp);
      push($sformatf("rnd%0d_do", i), SEL_DO, exp);
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
